// File: rtl/dmem_pkg.sv
// dmem_pkg: word width, default geometry and FSM state encoding shared by the
// data-memory responder, its bus interface and its storage.
package dmem_pkg;

    localparam int WORD_W        = 32;
    localparam int BE_W          = WORD_W / 8;
    localparam int ADDR_W        = 32;
    localparam int DEPTH_DEFAULT = 1024;
    localparam int WAIT_DEFAULT  = 2;

    // Plain vector constants keep the encoding visible to older tools and waveforms.
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_WAIT = 2'd1;
    localparam state_t S_RESP = 2'd2;

endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response handshake bundle between an initiator (master)
// and the data-memory responder (slave).
interface dmem_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [BE_W-1:0]   req_be;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_ram.sv
// dmem_ram: single-port word memory with per-byte write enables and a
// registered (synchronous) read port. Contents are never reset.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [BE_W-1:0]          be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Read-first: rdata reflects the word as it was before any write on the same edge.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-outstanding-request data memory with WAIT wait states.
// Define DMEM_ALIGN_CHECK_EN to reject word-misaligned accesses with resp_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WAIT  = WAIT_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LAST = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    state_t            state;
    logic [3:0]        wait_cnt;
    logic              resp_valid_q;
    logic              resp_err_q;

    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [AW-1:0]     idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic              err_q;

    logic              accept;
    logic              access;
    logic              misaligned;
    logic [WORD_W-1:0] ram_rdata;
    logic              unused_addr;

    assign bus.req_ready = (state == S_IDLE) && rst;
    assign accept        = bus.req_valid && bus.req_ready;
    // The memory is touched once, on the first edge spent in RESP.
    assign access        = (state == S_RESP) && !resp_valid_q && rst;
    assign unused_addr   = ^{bus.req_addr[ADDR_W-1:AW+2], bus.req_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned   = (bus.req_addr[1:0] != 2'b00);
    assign bus.resp_err = resp_err_q;
`else
    assign misaligned   = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    // Transaction fields are captured only at accept and are never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= bus.req_we;
            be_q    <= bus.req_be;
            idx_q   <= bus.req_addr[AW+1:2];
            wdata_q <= bus.req_wdata;
            err_q   <= misaligned;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            wait_cnt     <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state    <= (WAIT == 0) ? S_RESP : S_WAIT;
                        wait_cnt <= 4'd0;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state    <= S_RESP;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    if (!resp_valid_q) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= err_q;
                    end else if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    dmem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (access),
        .we    (we_q && !err_q),
        .be    (be_q),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // Writes and rejected accesses answer with zero; idle/reset also reads as zero.
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = (resp_valid_q && !we_q && !resp_err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder with a transaction-level
// reference model compared every cycle. Honours DMEM_ALIGN_CHECK_EN when defined.
module tb_dmem_responder;

    localparam int DEPTH_P = 1024;
    localparam int WAIT_P  = 2;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    dmem_if bus ();

    dmem_responder #(
        .DEPTH (DEPTH_P),
        .WAIT  (WAIT_P)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int passCount  = 0;
    int checkCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: one outstanding transaction, response 1+WAIT edges after accept.
    logic [31:0] mdl_mem   [DEPTH_P];
    bit          mdl_known [DEPTH_P];
    bit          mdl_init, mdl_busy, mdl_valid, mdl_rst_seen;
    int          mdl_age;
    bit          m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] mdl_rdata;
    bit          mdl_err, mdl_rdata_known;
    logic [9:0]  mdl_idx;

    always @(posedge clk) begin
        if (!rst) begin
            mdl_init     = 1'b1;
            mdl_busy     = 1'b0;
            mdl_valid    = 1'b0;
            mdl_age      = 0;
            mdl_rst_seen = 1'b1;
        end else begin
            mdl_rst_seen = 1'b0;
            if (!mdl_busy) begin
                if (bus.req_valid) begin
                    mdl_busy = 1'b1;
                    mdl_age  = 0;
                    m_we     = bus.req_we;
                    m_be     = bus.req_be;
                    m_addr   = bus.req_addr;
                    m_wdata  = bus.req_wdata;
                end
            end else if (!mdl_valid) begin
                mdl_age++;
                if (mdl_age == 1 + WAIT_P) begin
                    mdl_valid = 1'b1;
                    mdl_idx   = m_addr[11:2];
                    mdl_err   = ALIGN_ON && (m_addr[1:0] != 2'b00);
                    mdl_rdata_known = 1'b1;
                    mdl_rdata = 32'h0;
                    if (!mdl_err && m_we) begin
                        for (int i = 0; i < 4; i++) begin
                            if (m_be[i]) mdl_mem[mdl_idx][8*i +: 8] = m_wdata[8*i +: 8];
                        end
                        if (m_be == 4'hF) mdl_known[mdl_idx] = 1'b1;
                    end else if (!mdl_err) begin
                        mdl_rdata       = mdl_mem[mdl_idx];
                        mdl_rdata_known = mdl_known[mdl_idx];
                    end
                end
            end else if (bus.resp_ready) begin
                mdl_busy  = 1'b0;
                mdl_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_init) begin
            checkOutput("req_ready", 32'(bus.req_ready), 32'(!mdl_busy && rst));
            checkOutput("resp_valid", 32'(bus.resp_valid), 32'(mdl_valid));
            if (mdl_valid) begin
                checkOutput("resp_err", 32'(bus.resp_err), 32'(mdl_err));
                if (mdl_rdata_known) checkOutput("resp_rdata", bus.resp_rdata, mdl_rdata);
            end else if (mdl_rst_seen) begin
                checkOutput("reset_rdata", bus.resp_rdata, 32'h0);
                checkOutput("reset_err", 32'(bus.resp_err), 32'h0);
            end
        end
    end

    task automatic applyStimulus(input bit we, input logic [3:0] be, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int hold, input bit junk,
                                 output logic [31:0] rdata, output bit err, output int latency);
        bit ok = 1'b0;
        int n  = 0;
        rdata   = 32'h0;
        err     = 1'b0;
        latency = -1;
        @(posedge clk); #2;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_be    = be;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checkOutput("accept_timeout", 32'h0, 32'h1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #2;
        bus.req_valid = junk;
        bus.req_we    = 1'b1;
        bus.req_be    = 4'hF;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'hFFFF_FFFF;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin ok = 1'b1; break; end
            @(posedge clk);
            n++;
        end
        if (!ok) begin
            checkOutput("resp_timeout", 32'h0, 32'h1);
            bus.req_valid = 1'b0;
            return;
        end
        rdata   = bus.resp_rdata;
        err     = bus.resp_err;
        latency = n;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold_valid", 32'(bus.resp_valid), 32'h1);
            checkOutput("hold_req_ready", 32'(bus.req_ready), 32'h0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #2;
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        bit          er;
        int          lat;
        bit          ok;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_be     = 4'h0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b0;
        rst            = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        checkOutput("rst_resp_rdata", bus.resp_rdata, 32'h0);
        @(posedge clk); #2;
        rst = 1'b1;

        $display("[TB] full write then read");
        applyStimulus(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, rd, er, lat);
        checkOutput("wr_latency", 32'(lat), 32'd3);
        checkOutput("wr_rdata", rd, 32'h0);
        applyStimulus(1'b0, 4'hF, 32'h10, 32'h0, 0, 1'b0, rd, er, lat);
        checkOutput("rd_latency", 32'(lat), 32'd3);
        checkOutput("rd_full", rd, 32'hDEAD_BEEF);

        $display("[TB] byte-lane and empty-mask writes");
        applyStimulus(1'b1, 4'b0001, 32'h10, 32'h0000_00AA, 0, 1'b0, rd, er, lat);
        applyStimulus(0, 4'hF, 32'h10, 32'h0, 0, 1'b0, rd, er, lat);
        checkOutput("rd_byte0", rd, 32'hDEAD_BEAA);
        applyStimulus(1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF, 0, 1'b0, rd, er, lat);
        checkOutput("wr_be0_latency", 32'(lat), 32'd3);
        applyStimulus(0, 4'hF, 32'h10, 32'h0, 0, 1'b0, rd, er, lat);
        checkOutput("rd_after_be0", rd, 32'hDEAD_BEAA);

        $display("[TB] response back-pressure with junk requests");
        applyStimulus(0, 4'hF, 32'h10, 32'h0, 5, 1'b1, rd, er, lat);
        checkOutput("rd_held", rd, 32'hDEAD_BEAA);
        checkOutput("held_rdata_end", bus.resp_rdata, 32'h0);
        @(negedge clk);
        checkOutput("ready_after_handshake", 32'(bus.req_ready), 32'h1);
        applyStimulus(0, 4'hF, 32'h10, 32'h0, 0, 1'b0, rd, er, lat);
        checkOutput("rd_junk_ignored", rd, 32'hDEAD_BEAA);

        $display("[TB] reset during wait states");
        applyStimulus(1'b1, 4'hF, 32'h20, 32'h0BAD_F00D, 0, 1'b0, rd, er, lat);
        @(posedge clk); #2;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_be    = 4'hF;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h1234_5678;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin ok = 1'b1; break; end
        end
        checkOutput("abort_accept", 32'(ok), 32'h1);
        @(posedge clk); #2;
        bus.req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        @(posedge clk); #2;
        @(negedge clk);
        checkOutput("abort_valid_in_rst", 32'(bus.resp_valid), 32'h0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_ready_after_rst", 32'(bus.req_ready), 32'h1);
        checkOutput("abort_valid_after_rst", 32'(bus.resp_valid), 32'h0);
        applyStimulus(0, 4'hF, 32'h20, 32'h0, 0, 1'b0, rd, er, lat);
        checkOutput("rd_after_abort", rd, 32'h0BAD_F00D);

        $display("[TB] address wrap-around");
        applyStimulus(1'b1, 4'hF, 32'h1004, 32'hCAFE_F00D, 0, 1'b0, rd, er, lat);
        applyStimulus(0, 4'hF, 32'h0004, 32'h0, 0, 1'b0, rd, er, lat);
        checkOutput("rd_wrap", rd, 32'hCAFE_F00D);

        $display("[TB] misaligned read");
        applyStimulus(0, 4'hF, 32'h13, 32'h0, 0, 1'b0, rd, er, lat);
        checkOutput("misaligned_latency", 32'(lat), 32'd3);
`ifdef DMEM_ALIGN_CHECK_EN
        checkOutput("misaligned_err", 32'(er), 32'h1);
        checkOutput("misaligned_rdata", rd, 32'h0);
        applyStimulus(1'b1, 4'hF, 32'h11, 32'h5555_5555, 0, 1'b0, rd, er, lat);
        checkOutput("misaligned_wr_err", 32'(er), 32'h1);
        applyStimulus(0, 4'hF, 32'h10, 32'h0, 0, 1'b0, rd, er, lat);
        checkOutput("misaligned_wr_nochange", rd, 32'hDEAD_BEAA);
`else
        checkOutput("misaligned_err", 32'(er), 32'h0);
        checkOutput("misaligned_rdata", rd, 32'hDEAD_BEAA);
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d/%0d", passCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning memory size in 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT, default 2, meaning wait-state cycles between request accept and response (0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  initiator request valid.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_be  input  4  byte enables; bit i covers wdata[8i+7:8i].
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  write data.
REQ-011 SHALL have port resp_valid  output  1  response available.
REQ-012 SHALL have port resp_ready  input  1  initiator accepts the response.
REQ-013 SHALL have port resp_rdata  output  32  read data.
REQ-014 SHALL have port resp_err  output  1  access error flag.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE with rst high.
REQ-016 SHALL accept a request on the cycle req_valid && req_ready, latching we, be, addr, wdata.
REQ-017 SHALL go IDLE->WAIT on accept when WAIT>0, else IDLE->RESP directly.
REQ-018 SHALL count WAIT cycles in WAIT, then enter RESP; resp_valid rises exactly 1+WAIT cycles after the accept edge.
REQ-019 SHALL perform the memory access on entry to RESP, using word index addr[2+log2(DEPTH)-1:2]; upper address bits ignored (wrap-around).
REQ-020 SHALL on write update only bytes with be=1; be=4'b0000 writes nothing but still responds.
REQ-021 SHALL return the addressed word on reads and 32'h0 on writes in resp_rdata.
REQ-022 SHALL hold resp_valid, resp_rdata, resp_err stable in RESP until resp_ready=1, then return to IDLE on that edge.
REQ-023 SHALL not accept a new request in the cycle of the response handshake; next accept is possible one cycle later.
REQ-024 SHALL ignore req_* inputs outside IDLE.
REQ-025 SHALL treat a read following a write to the same word as returning the written data.

Reset
REQ-026 SHALL on rst low at a clock edge force IDLE, wait counter 0, resp_valid 0, resp_rdata 0, resp_err 0, and req_ready 0 while rst is low.
REQ-027 SHALL abort any transaction in progress on reset, with no partial write committed if reset occurs before RESP entry.
REQ-028 SHALL not clear memory contents on reset.

Configuration
REQ-029 SHALL, with macro DMEM_ALIGN_CHECK_EN defined, flag any access with req_addr[1:0]!=0: no memory change, resp_rdata 0, resp_err 1, same latency.
REQ-030 SHALL, without DMEM_ALIGN_CHECK_EN, ignore addr[1:0] and tie resp_err to 0.

Structure
REQ-031 SHALL place the FSM state enum, word width 32, and default DEPTH/WAIT constants in shared package dmem_pkg.
REQ-032 SHALL put storage in sub-module dmem_ram: single-port, byte-enable write, synchronous read, DEPTH words.

Verification
REQ-033 SHALL cover write 0xDEADBEEF to 0x10, be=4'hF, then read 0x10 -> resp_rdata 0xDEADBEEF, resp_valid at accept+3 with WAIT=2.
REQ-034 SHALL cover write 0x000000AA to 0x10 with be=4'b0001 over 0xDEADBEEF -> read returns 0xDEADBEAA.
REQ-035 SHALL cover resp_ready held low 5 cycles -> resp_valid and resp_rdata stable, req_ready 0 throughout, IDLE one cycle after handshake.
REQ-036 SHALL cover rst low during WAIT of a write to 0x20 -> resp_valid 0, word at 0x20 unchanged, req_ready 1 first cycle after rst high.
REQ-037 SHALL cover address wrap with DEPTH=1024: write to 0x1004, read 0x0004 -> same data.
REQ-038 SHALL cover read of 0x13: with DMEM_ALIGN_CHECK_EN resp_err 1, resp_rdata 0; without it resp_err 0, word at 0x10 returned.
